// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the five-stage MIPS-32 pipeline.
// Combines load-use and branch-operand hazards, the multi-cycle divider in E,
// memory wait states and M-stage exceptions into per-stage stall/flush controls.
// A small FSM tracks divide occupancy so the divide stays held in E until the
// divider has produced its result.
module hazard_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       branchD,
  input  logic       jrD,
  input  logic       MemtoRegE,
  input  logic       RegWriteE,
  input  logic [4:0] writeregE,
  input  logic       MemtoRegM,
  input  logic [4:0] writeregM,
  input  logic       div_startE,
  input  logic       inst_stall,
  input  logic       data_stall,
  input  logic       exceptionM,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       stallW,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       div_busy,
  output logic       div_done
);

  localparam int              CW        = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0]   CNT_INIT  = CW'(DIV_CYCLES - 2);
  localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV      = 2'd1,
    ST_DIV_HOLD = 2'd2
  } state_t;

  // True when a producer register is non-zero and feeds one of the D sources.
  function automatic logic src_match(input logic [4:0] dst,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt);
    src_match = (dst != 5'd0) && ((dst == rs) || (dst == rt));
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_div_busy;
  logic          w_busy_nxt;
  logic          r_div_done;
  logic          w_done_nxt;
  logic          w_lwstall;
  logic          w_brstall;
  logic          w_div_occupied;

  assign div_busy = r_div_busy;
  assign div_done = r_div_done;

  // Hazard detection from D sources against E/M destinations.
  always_comb begin
    w_lwstall = MemtoRegE & src_match(writeregE, rsD, rtD);
    w_brstall = (branchD | jrD) &
                ((RegWriteE & src_match(writeregE, rsD, rtD)) |
                 (MemtoRegM & src_match(writeregM, rsD, rtD)));
    w_div_occupied = (r_state == ST_DIV) || (r_state == ST_DIV_HOLD) ||
                     ((r_state == ST_RUN) && div_startE);
  end

  // Divide occupancy next-state; an exception aborts any divide in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_div_busy;
    w_done_nxt  = 1'b0;
    if (exceptionM) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = CNT_ZERO;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (div_startE) begin
            w_state_nxt = ST_DIV;
            w_cnt_nxt   = CNT_INIT;
            w_busy_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DIV: begin
          // The divider keeps counting through data-memory wait states.
          if (r_cnt != CNT_ZERO) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end else if (data_stall) begin
            w_state_nxt = ST_DIV_HOLD;
          end else begin
            w_state_nxt = ST_RUN;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
        ST_DIV_HOLD: begin
          if (!data_stall) begin
            w_state_nxt = ST_RUN;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_DIV_HOLD;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = CNT_ZERO;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // State, counter and registered divider status with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_cnt      <= CNT_ZERO;
      r_div_busy <= 1'b0;
      r_div_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_div_busy <= w_busy_nxt;
      r_div_done <= w_done_nxt;
    end
  end

  // Priority-ordered stall/flush decode; only the winning row drives any 1s.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    stallW = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (reset) begin
      stallF = 1'b0;
    end else if (exceptionM) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else if (data_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      stallW = 1'b1;
    end else if (w_div_occupied) begin
      // Hold the divide in E and feed bubbles into M.
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (w_lwstall | w_brstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else if (inst_stall) begin
      stallF = 1'b1;
      flushD = 1'b1;
    end else begin
      stallF = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hazard decode, divide occupancy, data_stall
// hold, exception abort and mid-divide reset. Each step applies inputs for one
// clock cycle and compares {stalls, flushes, div_busy, div_done} at the
// falling edge against hand-computed values.
module tb_hazard_ctrl;

  localparam int DC = 32;

  // Expected stall/flush vectors: {sF,sD,sE,sM,sW,fD,fE,fM,fW}
  localparam logic [8:0] O_NONE = 9'b00000_0000;
  localparam logic [8:0] O_EXC  = 9'b00000_1111;
  localparam logic [8:0] O_DST  = 9'b11111_0000;
  localparam logic [8:0] O_DIV  = 9'b11100_0010;
  localparam logic [8:0] O_HAZ  = 9'b11000_0100;
  localparam logic [8:0] O_IST  = 9'b10000_1000;

  logic       clk;
  logic       reset;
  logic [4:0] rsD, rtD, writeregE, writeregM;
  logic       branchD, jrD, MemtoRegE, RegWriteE, MemtoRegM;
  logic       div_startE, inst_stall, data_stall, exceptionM;
  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushD, flushE, flushM, flushW;
  logic       div_busy, div_done;

  int vec_cnt;
  int err_cnt;

  hazard_ctrl #(.DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
    .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE), .writeregE(writeregE),
    .MemtoRegM(MemtoRegM), .writeregM(writeregM),
    .div_startE(div_startE), .inst_stall(inst_stall), .data_stall(data_stall),
    .exceptionM(exceptionM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .div_busy(div_busy), .div_done(div_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [10:0] got, input logic [10:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Compare this cycle's outputs at the falling edge, then advance one cycle.
  task automatic step_chk(input string tag, input logic [8:0] eo,
                          input logic eb, input logic ed);
    @(negedge clk);
    check_val(tag, {stallF, stallD, stallE, stallM, stallW,
                    flushD, flushE, flushM, flushW, div_busy, div_done},
              {eo, eb, ed});
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rsD = 5'd0; rtD = 5'd0; writeregE = 5'd0; writeregM = 5'd0;
    branchD = 1'b0; jrD = 1'b0; MemtoRegE = 1'b0; RegWriteE = 1'b0;
    MemtoRegM = 1'b0; div_startE = 1'b0; inst_stall = 1'b0;
    data_stall = 1'b0; exceptionM = 1'b0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    // Outputs forced low while reset is high even with active causes.
    data_stall = 1'b1; exceptionM = 1'b1; inst_stall = 1'b1;
    step_chk("reset", O_NONE, 1'b0, 1'b0);
    reset = 1'b0;
    clear_inputs();
    step_chk("idle", O_NONE, 1'b0, 1'b0);

    // Hazard decode vectors.
    MemtoRegE = 1'b1; writeregE = 5'd5; rsD = 5'd5;
    step_chk("lw_rs", O_HAZ, 1'b0, 1'b0);
    writeregE = 5'd0; rsD = 5'd0;
    step_chk("lw_r0", O_NONE, 1'b0, 1'b0);
    writeregE = 5'd5; rsD = 5'd3; rtD = 5'd5;
    step_chk("lw_rt", O_HAZ, 1'b0, 1'b0);
    clear_inputs();
    branchD = 1'b1; rtD = 5'd8; RegWriteE = 1'b1; writeregE = 5'd8;
    step_chk("br_E", O_HAZ, 1'b0, 1'b0);
    branchD = 1'b0;
    step_chk("alu_nobr", O_NONE, 1'b0, 1'b0);
    clear_inputs();
    branchD = 1'b1; rtD = 5'd8; MemtoRegM = 1'b1; writeregM = 5'd8;
    step_chk("br_M", O_HAZ, 1'b0, 1'b0);
    clear_inputs();
    jrD = 1'b1; rsD = 5'd9; MemtoRegM = 1'b1; writeregM = 5'd9;
    step_chk("jr_M", O_HAZ, 1'b0, 1'b0);
    writeregM = 5'd10;
    step_chk("jr_miss", O_NONE, 1'b0, 1'b0);
    clear_inputs();
    inst_stall = 1'b1;
    step_chk("istall", O_IST, 1'b0, 1'b0);
    MemtoRegE = 1'b1; writeregE = 5'd4; rsD = 5'd4;
    step_chk("lw_istall", O_HAZ, 1'b0, 1'b0);
    data_stall = 1'b1;
    step_chk("dstall_lw", O_DST, 1'b0, 1'b0);
    exceptionM = 1'b1;
    step_chk("exc_dstall", O_EXC, 1'b0, 1'b0);
    clear_inputs();
    step_chk("idle2", O_NONE, 1'b0, 1'b0);

    // Plain divide; div_startE stays high while held to show it is ignored.
    div_startE = 1'b1;
    step_chk("div_t0", O_DIV, 1'b0, 1'b0);
    for (int k = 1; k < DC; k++) step_chk($sformatf("div_t%0d", k), O_DIV, 1'b1, 1'b0);
    div_startE = 1'b0;
    step_chk("div_done", O_NONE, 1'b0, 1'b1);
    step_chk("div_after", O_NONE, 1'b0, 1'b0);

    // Divide with data_stall over relative cycles 30..35.
    div_startE = 1'b1;
    step_chk("ds_t0", O_DIV, 1'b0, 1'b0);
    div_startE = 1'b0;
    for (int k = 1; k < 30; k++) step_chk($sformatf("ds_t%0d", k), O_DIV, 1'b1, 1'b0);
    data_stall = 1'b1;
    for (int k = 30; k < 36; k++) step_chk($sformatf("ds_t%0d", k), O_DST, 1'b1, 1'b0);
    data_stall = 1'b0;
    step_chk("ds_hold_rel", O_DIV, 1'b1, 1'b0);
    step_chk("ds_done", O_NONE, 1'b0, 1'b1);
    step_chk("ds_after", O_NONE, 1'b0, 1'b0);

    // Exception aborts a divide at relative cycle 10.
    div_startE = 1'b1;
    step_chk("ex_t0", O_DIV, 1'b0, 1'b0);
    div_startE = 1'b0;
    for (int k = 1; k < 10; k++) step_chk($sformatf("ex_t%0d", k), O_DIV, 1'b1, 1'b0);
    exceptionM = 1'b1;
    step_chk("ex_flush", O_EXC, 1'b1, 1'b0);
    exceptionM = 1'b0;
    for (int k = 11; k < DC + 4; k++) step_chk($sformatf("ex_t%0d", k), O_NONE, 1'b0, 1'b0);

    // Reset mid-divide, then a fresh divide restarts the full count.
    div_startE = 1'b1;
    step_chk("rs_t0", O_DIV, 1'b0, 1'b0);
    div_startE = 1'b0;
    for (int k = 1; k < 5; k++) step_chk($sformatf("rs_t%0d", k), O_DIV, 1'b1, 1'b0);
    reset = 1'b1;
    step_chk("rs_assert", O_NONE, 1'b1, 1'b0);
    reset = 1'b0;
    div_startE = 1'b1;
    step_chk("rs_restart", O_DIV, 1'b0, 1'b0);
    div_startE = 1'b0;
    for (int k = 1; k < DC; k++) step_chk($sformatf("rs_r%0d", k), O_DIV, 1'b1, 1'b0);
    step_chk("rs_done", O_NONE, 1'b0, 1'b1);
    step_chk("rs_after", O_NONE, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
